// File: rtl/tqvp_intercal_alu_seq.sv
// TinyQV peripheral that replays up to four queued ALU commands against a 32-bit
// accumulator. The combinational intercal_alu datapath is included here so the block stands alone.

package tqvp_intercal_alu_seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic        swap;
    logic [31:0] opnd;
  } cmd_t;

  localparam logic [5:0] ADDR_ACC    = 6'h00;
  localparam logic [5:0] ADDR_OPND   = 6'h08;
  localparam logic [5:0] ADDR_CMD    = 6'h0C;
  localparam logic [5:0] ADDR_STATUS = 6'h10;
  localparam logic [5:0] ADDR_CTRL   = 6'h14;
endpackage

// Op table: 0 add, 1 sub (x-y), 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra (shift by y[4:0]),
// 8 slt, 9 sltu, 10 min, 11 max, 12 minu, 13 maxu, 14 pass y, 15 nor.
module intercal_alu (
  input  logic [3:0]  op_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] f_o
);
  logic signed [31:0] xs;
  logic signed [31:0] ys;
  logic        [4:0]  sh;

  assign xs = x_i;
  assign ys = y_i;
  assign sh = y_i[4:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    f_o = '0;
    case (op_i)
      4'd0:  f_o = x_i + y_i;
      4'd1:  f_o = x_i - y_i;
      4'd2:  f_o = x_i & y_i;
      4'd3:  f_o = x_i | y_i;
      4'd4:  f_o = x_i ^ y_i;
      4'd5:  f_o = x_i << sh;
      4'd6:  f_o = x_i >> sh;
      4'd7:  f_o = $unsigned(xs >>> sh);
      4'd8:  f_o = {31'b0, xs < ys};
      4'd9:  f_o = {31'b0, x_i < y_i};
      4'd10: f_o = (xs < ys) ? x_i : y_i;
      4'd11: f_o = (xs < ys) ? y_i : x_i;
      4'd12: f_o = (x_i < y_i) ? x_i : y_i;
      4'd13: f_o = (x_i < y_i) ? y_i : x_i;
      4'd14: f_o = y_i;
      4'd15: f_o = ~(x_i | y_i);
      default: f_o = '0;
    endcase
  end
endmodule

module tqvp_intercal_alu_seq
  import tqvp_intercal_alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  state_e      state_q;
  cmd_t        cur_q;
  cmd_t        fifo_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic [31:0] acc_q, opnd_q;
  logic        busy_q, ovf_q, done_q, irq_en_q;

  logic        wr_any, wr_32;
  logic        wr_acc, wr_opnd, wr_cmd, wr_status, wr_ctrl, abort;
  logic        full, push, pop;
  logic [31:0] alu_x, alu_y, alu_f;
  logic [31:0] rd_word;
  logic        unused_ui;

  assign unused_ui = ^ui_in;
  assign uo_out    = '0;

  // Bus decode; ACC and OPND only accept full-word writes, ACC only while idle.
  assign wr_any    = (data_write_n != 2'b11);
  assign wr_32     = (data_write_n == 2'b10);
  assign wr_acc    = wr_32 && (address == ADDR_ACC) && (state_q == S_IDLE);
  assign wr_opnd   = wr_32 && (address == ADDR_OPND);
  assign wr_cmd    = wr_any && (address == ADDR_CMD);
  assign wr_status = wr_any && (address == ADDR_STATUS);
  assign wr_ctrl   = wr_any && (address == ADDR_CTRL);
  assign abort     = wr_ctrl && data_in[1];

  assign full    = (count_q == 3'd4);
  assign push    = wr_cmd && !full;
  assign pop     = (state_q == S_FETCH);
  assign count_d = abort ? 3'd0 : (count_q + {2'b0, push} - {2'b0, pop});

  assign alu_x = cur_q.swap ? cur_q.opnd : acc_q;
  assign alu_y = cur_q.swap ? acc_q : cur_q.opnd;

  intercal_alu u_alu (
    .op_i (cur_q.op),
    .x_i  (alu_x),
    .y_i  (alu_y),
    .f_o  (alu_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the FIFO storage is reset as well, so no stale command is ever visible after reset.
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{op: data_in[3:0], swap: data_in[4], opnd: opnd_q};
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  // Sequencer; IDLE looks at count_d so a command pushed from idle starts fetching on the push edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      busy_q <= (state_q != S_IDLE);
      if (wr_opnd) opnd_q   <= data_in;
      if (wr_ctrl) irq_en_q <= data_in[0];
      if (wr_acc)  acc_q    <= data_in;

      if (wr_cmd && full)              ovf_q <= 1'b1;
      else if (wr_status && data_in[2]) ovf_q <= 1'b0;

      if (!abort && state_q == S_DONE)  done_q <= 1'b1;
      else if (wr_status && data_in[3]) done_q <= 1'b0;

      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (count_d != 3'd0) state_q <= S_FETCH;
          end
          S_FETCH: begin
            cur_q   <= fifo_q[rd_ptr_q];
            state_q <= S_EXEC;
          end
          S_EXEC: begin
            acc_q   <= alu_f;
            state_q <= (count_d != 3'd0) ? S_FETCH : S_DONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign user_interrupt = done_q & irq_en_q;
  assign data_ready     = (data_read_n != 2'b11);

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_ACC:    rd_word = acc_q;
      ADDR_OPND:   rd_word = opnd_q;
      ADDR_STATUS: rd_word = {25'b0, count_q, done_q, ovf_q, full, busy_q};
      ADDR_CTRL:   rd_word = {31'b0, irq_en_q};
      default:     rd_word = '0;
    endcase
    data_out = '0;
    case (data_read_n)
      2'b00:   data_out = {24'b0, rd_word[7:0]};
      2'b01:   data_out = {16'b0, rd_word[15:0]};
      2'b10:   data_out = rd_word;
      default: data_out = '0;
    endcase
  end
endmodule
